// File: rtl/ov7670_pkg.sv
// Shared types and helpers for the OV7670 pixel-capture write controller.
// Provides the capture FSM state type, output-geometry helpers used to
// size address arithmetic, and the luma-to-RGB565 grey conversion.
package ov7670_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        CAPTURE
    } cap_state_t;

    // Output dimension after decimation (sensor active size / factor).
    function automatic int out_dim(input int active, input int decim);
        return active / decim;
    endfunction

    // Shift amount equivalent to dividing by the decimation factor (1/2/4).
    function automatic int decim_shift(input int decim);
        return (decim >= 4) ? 2 : ((decim >= 2) ? 1 : 0);
    endfunction

    // Replicate the luma MSBs into all three RGB565 fields to get a grey pixel.
    function automatic logic [15:0] rgb565_from_y(input logic [7:0] y);
        return {y[7:3], y[7:2], y[7:3]};
    endfunction

endpackage

// File: rtl/ov7670_sync_edge.sv
// Registers the sensor href/vsync lines once and derives single-pclk
// rise/fall pulses from the registered copies.
// Ports:
//   pclk, reset          sensor clock, synchronous active-high reset
//   href, vsync          raw sensor sync inputs
//   href_lvl             registered href level
//   href_rise/href_fall  one-pclk pulses on registered href edges
//   vsync_rise/vsync_fall one-pclk pulses on registered vsync edges
module ov7670_sync_edge (
    input  logic pclk,
    input  logic reset,
    input  logic href,
    input  logic vsync,
    output logic href_lvl,
    output logic href_rise,
    output logic href_fall,
    output logic vsync_rise,
    output logic vsync_fall
);

    logic href_q, href_d, href_prev_q, href_prev_d;
    logic vsync_q, vsync_d, vsync_prev_q, vsync_prev_d;

    // Next-state: one register stage for the level, one more for edge history.
    always_comb begin
        href_d       = href;
        href_prev_d  = href_q;
        vsync_d      = vsync;
        vsync_prev_d = vsync_q;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            href_q       <= 1'b0;
            href_prev_q  <= 1'b0;
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else begin
            href_q       <= href_d;
            href_prev_q  <= href_prev_d;
            vsync_q      <= vsync_d;
            vsync_prev_q <= vsync_prev_d;
        end
    end

    assign href_lvl   = href_q;
    assign href_rise  = href_q & ~href_prev_q;
    assign href_fall  = ~href_q & href_prev_q;
    assign vsync_rise = vsync_q & ~vsync_prev_q;
    assign vsync_fall = ~vsync_q & vsync_prev_q;

endmodule

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 pixel-capture write controller. Assembles two-byte pixels from the
// sensor bus, decimates by 1/2/4 in both axes, optionally converts YUYV luma
// to grey RGB565, and emits frame-buffer writes with a contiguous address.
// Ports:
//   pclk, reset   sensor pixel clock, synchronous active-high reset
//   href, vsync   sensor line-valid / frame sync
//   data          sensor byte bus
//   arm, cont     capture enable level; continuous vs single-frame mode
//   fmt_gray      0: RGB565 pass-through, 1: YUYV luma to grey
//   we/wAddr/wData frame-buffer write port
//   frame_done    one-pclk pulse at end of a captured frame
//   line_err      sticky line-length / line-count error, cleared at frame start
//   busy          high while capturing
module ov7670_capture_ctrl
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DECIM    = 2,
    parameter int ADDR_W   = 17
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              href,
    input  logic              vsync,
    input  logic [7:0]        data,
    input  logic              arm,
    input  logic              cont,
    input  logic              fmt_gray,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              frame_done,
    output logic              line_err,
    output logic              busy
);

    localparam int H_OUT = out_dim(H_ACTIVE, DECIM);
    localparam int SH    = decim_shift(DECIM);
    localparam int XW    = $clog2(H_ACTIVE + 2);
    localparam int YW    = $clog2(V_ACTIVE + 2);

    // Counters saturate one past the active size so overlong lines/frames
    // still read as "not equal" without wrapping back into the kept range.
    localparam logic [XW-1:0]     X_MASK    = XW'(DECIM - 1);
    localparam logic [XW-1:0]     X_END     = XW'(H_ACTIVE);
    localparam logic [XW-1:0]     X_SAT     = XW'(H_ACTIVE + 1);
    localparam logic [YW-1:0]     Y_MASK    = YW'(DECIM - 1);
    localparam logic [YW-1:0]     Y_END     = YW'(V_ACTIVE);
    localparam logic [YW-1:0]     Y_SAT     = YW'(V_ACTIVE + 1);
    localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(H_OUT);

    logic href_lvl, href_rise, href_fall, vsync_rise, vsync_fall;

    ov7670_sync_edge u_sync (
        .pclk       (pclk),
        .reset      (reset),
        .href       (href),
        .vsync      (vsync),
        .href_lvl   (href_lvl),
        .href_rise  (href_rise),
        .href_fall  (href_fall),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall)
    );

    cap_state_t        state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        hi_q, hi_d;
    logic              phase_q, phase_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              hold_q, hold_d;
    logic              cur_phase, x_keep, y_keep;

    // Capture FSM plus pixel assembly. The data byte is registered alongside
    // href so the byte stream stays aligned with the registered sync copies.
    // hold_q blocks re-arming after a single frame until arm is dropped.
    always_comb begin
        state_d     = state_q;
        data_d      = data;
        hi_d        = hi_q;
        phase_d     = phase_q;
        x_d         = x_q;
        y_d         = y_q;
        line_base_d = line_base_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        done_d      = 1'b0;
        err_d       = err_q;
        hold_d      = hold_q;

        cur_phase = href_rise ? 1'b0 : phase_q;
        x_keep    = ((x_q & X_MASK) == '0) && (x_q < X_END);
        y_keep    = ((y_q & Y_MASK) == '0) && (y_q < Y_END);

        if (!arm) begin
            hold_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (arm && !hold_q) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (!arm) begin
                    state_d = IDLE;
                end else if (vsync_fall) begin
                    state_d     = CAPTURE;
                    x_d         = '0;
                    y_d         = '0;
                    line_base_d = '0;
                    err_d       = 1'b0;
                    phase_d     = 1'b0;
                end
            end
            CAPTURE: begin
                if (!arm) begin
                    state_d = IDLE;
                end else if (vsync_rise) begin
                    done_d = 1'b1;
                    if (y_q != Y_END) begin
                        err_d = 1'b1;
                    end
                    if (cont) begin
                        state_d = SYNC;
                    end else begin
                        state_d = IDLE;
                        hold_d  = 1'b1;
                    end
                end else if (href_lvl) begin
                    phase_d = ~cur_phase;
                    if (!cur_phase) begin
                        hi_d = data_q;
                    end else begin
                        if (x_q != X_SAT) begin
                            x_d = x_q + 1'b1;
                        end
                        if (x_keep && y_keep) begin
                            we_d    = 1'b1;
                            waddr_d = line_base_q + ADDR_W'(x_q >> SH);
                            wdata_d = fmt_gray ? rgb565_from_y(hi_q) : {hi_q, data_q};
                        end
                    end
                end else if (href_fall) begin
                    if (x_q != X_END) begin
                        err_d = 1'b1;
                    end
                    if (y_q != Y_SAT) begin
                        y_d = y_q + 1'b1;
                    end
                    if (y_keep) begin
                        line_base_d = line_base_q + BASE_STEP;
                    end
                    x_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CAPTURE);
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            hi_q        <= '0;
            phase_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            line_base_q <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            hi_q        <= hi_d;
            phase_q     <= phase_d;
            x_q         <= x_d;
            y_q         <= y_d;
            line_base_q <= line_base_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            hold_q      <= hold_d;
        end
    end

    assign we         = we_q;
    assign wAddr      = waddr_q;
    assign wData      = wdata_q;
    assign frame_done = done_q;
    assign line_err   = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Bench for ov7670_capture_ctrl. Two scaled-down instances share the sensor
// inputs: A is 16x8 with decimation 2, B is 8x4 with decimation 1. Each
// scenario resets both and checks the selected instance against a model.
module tb_ov7670_capture_ctrl;

    logic       pclk    = 1'b0;
    logic       reset   = 1'b1;
    logic       href    = 1'b0;
    logic       vsync   = 1'b0;
    logic [7:0] data    = 8'h00;
    logic       arm     = 1'b0;
    logic       cont    = 1'b0;
    logic       fmtGray = 1'b0;

    logic        weA, doneA, errA, busyA;
    logic [5:0]  wAddrA;
    logic [15:0] wDataA;
    logic        weB, doneB, errB, busyB;
    logic [5:0]  wAddrB;
    logic [15:0] wDataB;

    always #5 pclk = ~pclk;

    ov7670_capture_ctrl #(.H_ACTIVE(16), .V_ACTIVE(8), .DECIM(2), .ADDR_W(6)) dutA (
        .pclk(pclk), .reset(reset), .href(href), .vsync(vsync), .data(data),
        .arm(arm), .cont(cont), .fmt_gray(fmtGray),
        .we(weA), .wAddr(wAddrA), .wData(wDataA),
        .frame_done(doneA), .line_err(errA), .busy(busyA)
    );

    ov7670_capture_ctrl #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(1), .ADDR_W(6)) dutB (
        .pclk(pclk), .reset(reset), .href(href), .vsync(vsync), .data(data),
        .arm(arm), .cont(cont), .fmt_gray(fmtGray),
        .we(weB), .wAddr(wAddrB), .wData(wDataB),
        .frame_done(doneB), .line_err(errB), .busy(busyB)
    );

    typedef struct {
        int dutSel;
        bit gray;
        int lines;
        int len;
        int shortLine;
        int shortLen;
        int expWrites;
        bit expErr;
    } vec_t;

    vec_t vecs[8];
    int checks = 0;
    int errors = 0;
    int monSel = 0;
    int doneCnt = 0;
    logic [5:0]  addrQ[$];
    logic [15:0] dataQ[$];

    // Record writes and frame_done pulses of the selected instance mid-cycle.
    always @(negedge pclk) begin
        if (!reset) begin
            if (monSel == 0) begin
                if (weA) begin
                    addrQ.push_back(wAddrA);
                    dataQ.push_back(wDataA);
                end
                if (doneA) doneCnt++;
            end else begin
                if (weB) begin
                    addrQ.push_back(wAddrB);
                    dataQ.push_back(wDataB);
                end
                if (doneB) doneCnt++;
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic clearMon();
        addrQ.delete();
        dataQ.delete();
        doneCnt = 0;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        arm   = 1'b0;
        href  = 1'b0;
        vsync = 1'b0;
        data  = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    function automatic logic [7:0] byteHi(input int y, input int x);
        logic [7:0] v;
        if (fmtGray) v = (x % 2 != 0) ? 8'h00 : 8'hFF;
        else         v = 8'(y * 16 + x);
        return v;
    endfunction

    function automatic logic [7:0] byteLo(input int y, input int x);
        logic [7:0] v;
        if (fmtGray) v = 8'h80;
        else         v = ~byteHi(y, x);
        return v;
    endfunction

    function automatic bit keepPix(input int sel, input int y, input int x);
        if (sel == 0) return (y % 2 == 0) && (x % 2 == 0) && (x < 16) && (y < 8);
        return (x < 8) && (y < 4);
    endfunction

    function automatic int expAddr(input int sel, input int y, input int x);
        return (sel == 0) ? ((y / 2) * 8 + x / 2) : (y * 8 + x);
    endfunction

    function automatic logic [15:0] expData(input int y, input int x);
        logic [7:0] hi;
        if (fmtGray) return (x % 2 != 0) ? 16'h0000 : 16'hFFFF;
        hi = 8'(y * 16 + x);
        return {hi, ~hi};
    endfunction

    // One sensor frame: vsync pulse, then lines of 2-byte pixels with gaps.
    // armLine raises arm at that line start; abortLine drops it there.
    task automatic applyStimulus(input int lines, input int len, input int shortLine,
                                 input int shortLen, input int armLine, input int abortLine);
        int n;
        vsync = 1'b1;
        repeat (4) tick();
        vsync = 1'b0;
        repeat (4) tick();
        for (int y = 0; y < lines; y++) begin
            if (y == armLine) arm = 1'b1;
            if (y == abortLine) begin
                arm = 1'b0;
                tick();
                checkOutput("abort busy", int'(busyA), 0);
            end
            n = (y == shortLine) ? shortLen : len;
            href = 1'b1;
            for (int x = 0; x < n; x++) begin
                data = byteHi(y, x);
                tick();
                data = byteLo(y, x);
                tick();
            end
            href = 1'b0;
            data = 8'h00;
            repeat (4) tick();
        end
        repeat (4) tick();
        vsync = 1'b1;
        repeat (4) tick();
    endtask

    // Compare the recorded write stream from index offset against the model.
    task automatic checkStream(input string name, input int sel, input int lines, input int len,
                               input int shortLine, input int shortLen, input int offset);
        int k;
        int bad;
        int n;
        k = offset;
        bad = 0;
        for (int y = 0; y < lines; y++) begin
            n = (y == shortLine) ? shortLen : len;
            for (int x = 0; x < n; x++) begin
                if (keepPix(sel, y, x)) begin
                    if (k >= addrQ.size()) bad++;
                    else if (int'(addrQ[k]) != expAddr(sel, y, x) || dataQ[k] != expData(y, x)) bad++;
                    k++;
                end
            end
        end
        checkOutput(name, bad, 0);
    endtask

    initial begin
        vecs[0] = '{0, 1'b0, 8, 16, -1, 0, 32, 1'b0};
        vecs[1] = '{0, 1'b0, 8, 16, 2, 14, 31, 1'b1};
        vecs[2] = '{0, 1'b0, 8, 16, 3, 14, 32, 1'b1};
        vecs[3] = '{0, 1'b0, 7, 16, -1, 0, 32, 1'b1};
        vecs[4] = '{0, 1'b0, 8, 16, 0, 18, 32, 1'b1};
        vecs[5] = '{1, 1'b1, 4, 8, -1, 0, 32, 1'b0};
        vecs[6] = '{0, 1'b1, 8, 16, -1, 0, 32, 1'b0};
        vecs[7] = '{0, 1'b0, 10, 16, -1, 0, 32, 1'b1};

        resetDut();
        checkOutput("reset we", int'(weA), 0);
        checkOutput("reset wAddr", int'(wAddrA), 0);
        checkOutput("reset wData", int'(wDataA), 0);
        checkOutput("reset frame_done", int'(doneA), 0);
        checkOutput("reset line_err", int'(errA), 0);
        checkOutput("reset busy", int'(busyA), 0);

        for (int i = 0; i < 8; i++) begin
            resetDut();
            monSel  = vecs[i].dutSel;
            fmtGray = vecs[i].gray;
            cont    = 1'b0;
            arm     = 1'b1;
            clearMon();
            applyStimulus(vecs[i].lines, vecs[i].len, vecs[i].shortLine, vecs[i].shortLen, -1, -1);
            checkOutput($sformatf("v%0d writes", i), addrQ.size(), vecs[i].expWrites);
            checkStream($sformatf("v%0d stream", i), vecs[i].dutSel, vecs[i].lines, vecs[i].len,
                        vecs[i].shortLine, vecs[i].shortLen, 0);
            checkOutput($sformatf("v%0d frame_done", i), doneCnt, 1);
            checkOutput($sformatf("v%0d line_err", i),
                        int'(monSel == 0 ? errA : errB), int'(vecs[i].expErr));
            checkOutput($sformatf("v%0d busy", i), int'(monSel == 0 ? busyA : busyB), 0);
            clearMon();
            applyStimulus(vecs[i].lines, vecs[i].len, -1, 0, -1, -1);
            checkOutput($sformatf("v%0d 2nd frame writes", i), addrQ.size(), 0);
            checkOutput($sformatf("v%0d 2nd frame done", i), doneCnt, 0);
        end

        // Continuous mode, arm dropped partway through the third frame.
        resetDut();
        monSel = 0; fmtGray = 1'b0; cont = 1'b1; arm = 1'b1;
        clearMon();
        applyStimulus(8, 16, -1, 0, -1, -1);
        applyStimulus(8, 16, -1, 0, -1, -1);
        applyStimulus(8, 16, -1, 0, -1, 3);
        checkOutput("cont frame_done", doneCnt, 2);
        checkOutput("cont writes", addrQ.size(), 80);
        checkStream("cont frame2 stream", 0, 8, 16, -1, 0, 32);
        checkStream("cont frame3 stream", 0, 3, 16, -1, 0, 64);

        // Arm raised mid-frame: that frame is skipped, the next starts at 0.
        resetDut();
        cont = 1'b0;
        clearMon();
        applyStimulus(8, 16, -1, 0, 5, -1);
        checkOutput("midarm partial writes", addrQ.size(), 0);
        checkOutput("midarm partial done", doneCnt, 0);
        checkOutput("midarm busy", int'(busyA), 0);
        applyStimulus(8, 16, -1, 0, -1, -1);
        checkOutput("midarm writes", addrQ.size(), 32);
        checkOutput("midarm first addr", addrQ.size() > 0 ? int'(addrQ[0]) : -1, 0);
        checkOutput("midarm done", doneCnt, 1);

        // line_err set by a short line, cleared when the next frame starts.
        resetDut();
        cont = 1'b1; arm = 1'b1;
        clearMon();
        applyStimulus(8, 16, 3, 14, -1, -1);
        checkOutput("err short line", int'(errA), 1);
        applyStimulus(8, 16, -1, 0, -1, -1);
        checkOutput("err cleared", int'(errA), 0);
        checkOutput("err writes", addrQ.size(), 64);
        checkStream("err frame2 stream", 0, 8, 16, -1, 0, 32);
        checkOutput("err done", doneCnt, 2);

        // Reset pulsed in the middle of a line while capturing.
        resetDut();
        cont = 1'b1; arm = 1'b1;
        vsync = 1'b1;
        repeat (4) tick();
        vsync = 1'b0;
        repeat (4) tick();
        href = 1'b1;
        for (int b = 0; b < 5; b++) begin
            data = 8'(8'h55 + b);
            tick();
        end
        checkOutput("pre-reset busy", int'(busyA), 1);
        reset = 1'b1;
        href  = 1'b0;
        tick();
        checkOutput("mid reset we", int'(weA), 0);
        checkOutput("mid reset wAddr", int'(wAddrA), 0);
        checkOutput("mid reset wData", int'(wDataA), 0);
        checkOutput("mid reset frame_done", int'(doneA), 0);
        checkOutput("mid reset line_err", int'(errA), 0);
        checkOutput("mid reset busy", int'(busyA), 0);
        reset = 1'b0;
        tick();
        clearMon();
        applyStimulus(8, 16, -1, 0, -1, -1);
        checkOutput("resync writes", addrQ.size(), 32);
        checkOutput("resync first data", dataQ.size() > 0 ? int'(dataQ[0]) : -1, 16'h00FF);
        checkStream("resync stream", 0, 8, 16, -1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
